mem_bus_responder: RTL and testbench

- Memory-mapped data-memory responder for the core's load/store bus. The pipelined core is the initiator; this block is the other end.
- Accepts one request at a time over a valid/ready handshake and models a configurable number of wait states.
- Performs byte-lane-masked writes, returns read data, and flags misaligned or out-of-range accesses.
- Used as the data-side memory model in core-level simulation and as the on-chip SRAM responder in the SoC.

---
 rtl/mem_bus_responder.sv | 135 +++++++++++++
 tb/tb_mem_bus_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Data-memory responder for the core's load/store bus: one request at a time,
// configurable wait states, byte-masked stores, misaligned/out-of-range errors.
module mem_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN    = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, enter_resp;

  logic        hold_we;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_be;

  logic        src_we;
  logic [31:0] src_addr, src_wdata;
  logic [3:0]  src_be;

  logic [32:0]   offset;
  logic          acc_err;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic        err_q;

  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign accept      = i_req_valid && o_req_ready;

  // With zero wait states the access is evaluated on the acceptance edge itself,
  // so the live request must be used instead of the not-yet-loaded holding registers.
  assign src_we    = (state == IDLE) ? i_req_we    : hold_we;
  assign src_addr  = (state == IDLE) ? i_req_addr  : hold_addr;
  assign src_wdata = (state == IDLE) ? i_req_wdata : hold_wdata;
  assign src_be    = (state == IDLE) ? i_req_be    : hold_be;

  // 33-bit subtraction: an address below the base wraps into the top bit and fails the range check.
  assign offset  = {1'b0, src_addr} - {1'b0, BASE_ADDR};
  assign acc_err = (|src_addr[1:0]) || (offset >= SPAN);
  assign idx     = offset[AW+1:2];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && accept) begin
      hold_we    <= i_req_we;
      hold_addr  <= i_req_addr;
      hold_wdata <= i_req_wdata;
      hold_be    <= i_req_be;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= acc_err;
      rdata_q <= (acc_err || src_we) ? 32'd0 : mem[idx];
    end
  end

  // Writes commit only on the RESP-entry edge, so a reset before then discards them.
  always_ff @(posedge i_clk) begin
    if (!i_rst && enter_resp && src_we && !acc_err) begin
      for (int n = 0; n < 4; n++) begin
        if (src_be[n]) mem[idx][8*n +: 8] <= src_wdata[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: a transaction-level reference model checked every
// cycle, directed vectors with literal expectations, and a zero-wait-state instance.
module tb_mem_bus_responder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 1024;
  localparam int          WS    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        rst_b, req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [31:0] req_addr_b, req_wdata_b, rsp_rdata_b;
  logic [3:0]  req_be_b;

  int total = 0;
  int bad   = 0;

  mem_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
  );

  mem_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_req_valid(req_valid_b), .o_req_ready(req_ready_b),
    .i_req_we(req_we_b), .i_req_addr(req_addr_b), .i_req_wdata(req_wdata_b), .i_req_be(req_be_b),
    .o_rsp_valid(rsp_valid_b), .i_rsp_ready(rsp_ready_b), .o_rsp_rdata(rsp_rdata_b), .o_rsp_err(rsp_err_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks one outstanding transaction by its remaining latency
  // and resolves it against a sparse word store when the latency expires.
  logic [31:0] model_mem [int];
  bit          live = 0, pend = 0, exp_ready, exp_valid, exp_err, data_chk, exp_known;
  logic [31:0] exp_rdata;
  int          countdown;
  bit          p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;

  function automatic void resolve();
    longint      off;
    int          widx;
    logic [31:0] w;
    off  = longint'(p_addr) - longint'(BASE);
    pend = 1'b0;
    exp_valid = 1'b1;
    data_chk  = 1'b1;
    exp_known = 1'b1;
    if ((p_addr % 4) != 0 || off < 0 || off >= 4 * DEPTH) begin
      exp_err   = 1'b1;
      exp_rdata = 32'd0;
    end else begin
      widx    = int'(off / 4);
      exp_err = 1'b0;
      if (p_we) begin
        w = model_mem.exists(widx) ? model_mem[widx] : 32'hxxxx_xxxx;
        for (int n = 0; n < 4; n++) if (p_be[n]) w[8*n +: 8] = p_wdata[8*n +: 8];
        model_mem[widx] = w;
        exp_rdata = 32'd0;
      end else if (model_mem.exists(widx)) begin
        exp_rdata = model_mem[widx];
        exp_known = !$isunknown(exp_rdata);
      end else begin
        exp_rdata = 32'd0;
        exp_known = 1'b0;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      live = 1; pend = 0; exp_ready = 1; exp_valid = 0;
      exp_rdata = 32'd0; exp_err = 0; data_chk = 1; exp_known = 1;
    end else if (live) begin
      if (exp_valid) begin
        if (rsp_ready) begin
          exp_valid = 0; exp_ready = 1; data_chk = 0;
        end
      end else if (pend) begin
        countdown--;
        if (countdown == 0) resolve();
      end else if (exp_ready && req_valid) begin
        p_we = req_we; p_addr = req_addr; p_wdata = req_wdata; p_be = req_be;
        exp_ready = 0; pend = 1; countdown = WS;
        if (WS == 0) resolve();
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (data_chk) begin
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (exp_known) checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
      end
    end
  end

  // Issues one transaction from a falling edge, holds off the response for
  // 'stall' cycles, and returns on the falling edge after the handshake.
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int stall,
                               output logic [31:0] rdata, output logic err, output int lat);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      bad++; total++;
      $display("[TB] FAIL ready_timeout: got 0 expected 1 at %0t", $time);
    end
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; rsp_ready = 0;
    @(negedge clk);
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      bad++; total++;
      $display("[TB] FAIL rsp_timeout: got 0 expected 1 at %0t", $time);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    repeat (stall) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] exp_b [16];
  int          acc_cyc [16];

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
    rst_b = 1; req_valid_b = 0; req_we_b = 0; req_addr_b = 0; req_wdata_b = 0; req_be_b = 0; rsp_ready_b = 1;
    repeat (2) @(negedge clk);
    rst = 0; rst_b = 0;
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'd0);

    applyStimulus(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    checkOutput("t1_st_lat", 32'(lat), 32'd3);
    checkOutput("t1_st_err", 32'(er), 32'd0);
    checkOutput("t1_st_rdata", rd, 32'd0);
    applyStimulus(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    checkOutput("t1_ld_lat", 32'(lat), 32'd3);
    checkOutput("t1_ld_rdata", rd, 32'hDEAD_BEEF);

    applyStimulus(1, 32'h20, 32'hAABB_CCDD, 4'hF, 0, rd, er, lat);
    applyStimulus(1, 32'h20, 32'h1122_3344, 4'b0101, 0, rd, er, lat);
    applyStimulus(1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, rd, er, lat);
    checkOutput("t2_be0_err", 32'(er), 32'd0);
    applyStimulus(0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
    checkOutput("t2_merge", rd, 32'hAA22_CC44);

    applyStimulus(0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat);
    checkOutput("t3_rdata", rd, 32'hDEAD_BEEF);
    checkOutput("t3_held_rdata", rsp_rdata, 32'hDEAD_BEEF);
    checkOutput("t3_idle", 32'(req_ready), 32'd1);

    applyStimulus(1, 32'hFFC, 32'h0BAD_F00D, 4'hF, 0, rd, er, lat);
    applyStimulus(0, 32'h12, 32'h0, 4'hF, 0, rd, er, lat);
    checkOutput("t4_misal_err", 32'(er), 32'd1);
    checkOutput("t4_misal_rdata", rd, 32'd0);
    applyStimulus(1, 32'h1000, 32'h7777_7777, 4'hF, 0, rd, er, lat);
    checkOutput("t4_oor_err", 32'(er), 32'd1);
    applyStimulus(0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, rd, er, lat);
    checkOutput("t4_wrap_err", 32'(er), 32'd1);
    applyStimulus(0, 32'hFFC, 32'h0, 4'hF, 0, rd, er, lat);
    checkOutput("t4_last_err", 32'(er), 32'd0);
    checkOutput("t4_last_rdata", rd, 32'h0BAD_F00D);

    applyStimulus(1, 32'h30, 32'h1234_5678, 4'hF, 0, rd, er, lat);
    req_valid = 1; req_we = 1; req_addr = 32'h30; req_wdata = 32'h5555_5555; req_be = 4'hF;
    @(negedge clk);
    req_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    checkOutput("t5_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t5_novalid", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(0, 32'h30, 32'h0, 4'hF, 0, rd, er, lat);
    checkOutput("t5_rdata", rd, 32'h1234_5678);

    // Zero-wait-state instance: 8 stores then 8 loads, response always accepted.
    for (int i = 0; i < 16; i++) exp_b[i] = (i < 8) ? 32'd0 : 32'hC0DE_0000 + 32'(i - 8);
    begin
      int cyc = 0, nacc = 0, nrsp = 0;
      while (nrsp < 16 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (rsp_valid_b) begin
          if (nrsp < 16) begin
            checkOutput("t6_rdata", rsp_rdata_b, exp_b[nrsp]);
            checkOutput("t6_err", 32'(rsp_err_b), 32'd0);
            checkOutput("t6_lat", 32'(cyc - acc_cyc[nrsp]), 32'd1);
          end
          nrsp++;
        end
        if (req_ready_b && nacc < 16) begin
          req_valid_b = 1;
          req_we_b    = (nacc < 8);
          req_addr_b  = 32'h40 + 32'(4 * (nacc % 8));
          req_wdata_b = (nacc < 8) ? 32'hC0DE_0000 + 32'(nacc) : 32'hFFFF_FFFF;
          req_be_b    = 4'hF;
          acc_cyc[nacc] = cyc;
          if (nacc > 0) checkOutput("t6_gap", 32'(cyc - acc_cyc[nacc-1]), 32'd2);
          nacc++;
        end else begin
          req_valid_b = 0;
        end
      end
      checkOutput("t6_count", 32'(nrsp), 32'd16);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
